// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx
// Purpose  : UART receiver, 16x oversampled, 8N1 frames (1 start bit low,
//            8 data bits MSB first, 1 stop bit high, no parity). Each bit
//            is decided by a 3-sample majority vote around mid-bit.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk        in   system clock
//   rst        in   asynchronous, active-high reset
//   baud_tick  in   one-clk enable at 16x the baud rate
//   rx         in   asynchronous serial line (idles high)
//   rx_data    out  [7:0] last received byte, held until the next frame ends
//   rx_valid   out  one-clk pulse: rx_data holds a good frame
//   frame_err  out  one-clk pulse: stop bit voted low (rx_data still updated)
//   busy       out  high whenever the receiver is not idle
// ============================================================================
module uart_rx #(
  parameter int OVERSAMPLE  = 16,  // only 16 is supported (4-bit tick counter)
  parameter int SYNC_STAGES = 2    // rx synchronizer depth, minimum 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       baud_tick,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       busy
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_START = 2'd1;
  localparam logic [1:0] c_DATA  = 2'd2;
  localparam logic [1:0] c_STOP  = 2'd3;

  // Tick positions inside one bit period.
  localparam logic [3:0] c_TICK_LAST = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] c_TICK_MID  = 4'(OVERSAMPLE / 2);
  localparam logic [3:0] c_TICK_S0   = 4'(OVERSAMPLE / 2 - 2);
  localparam logic [3:0] c_TICK_S1   = 4'(OVERSAMPLE / 2 - 1);

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_q;
  logic [1:0]             state_q,     state_d;
  logic [3:0]             tick_cnt_q,  tick_cnt_d;
  logic [2:0]             bit_cnt_q,   bit_cnt_d;
  logic [7:0]             sreg_q,      sreg_d;
  logic [1:0]             samp_q,      samp_d;
  logic [7:0]             rx_data_q,   rx_data_d;
  logic                   rx_valid_q,  rx_valid_d;
  logic                   frame_err_q, frame_err_d;
  logic                   busy_q,      busy_d;

  logic                   rx_s;
  logic                   vote;
  logic                   decide;

  // --------------------------------------------------------------------------
  // Metastability synchronizer. Resets to all ones so a reset does not look
  // like a start bit.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
    end
  end

  assign rx_s = sync_q[SYNC_STAGES-1];

  // Third sample is taken live on the decision tick, so the vote is
  // resolved without an extra tick of delay.
  assign vote   = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s) | (samp_q[1] & rx_s);
  assign decide = baud_tick && (tick_cnt_q == c_TICK_MID);

  // --------------------------------------------------------------------------
  // State and datapath register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= c_IDLE;
      tick_cnt_q  <= 4'd0;
      bit_cnt_q   <= 3'd0;
      sreg_q      <= 8'h00;
      samp_q      <= 2'b11;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      tick_cnt_q  <= tick_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      sreg_q      <= sreg_d;
      samp_q      <= samp_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      busy_q      <= busy_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic: everything here advances only on baud ticks.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    sreg_d     = sreg_q;
    samp_d     = samp_q;

    if (baud_tick) begin
      if (tick_cnt_q == c_TICK_S0) samp_d[0] = rx_s;
      if (tick_cnt_q == c_TICK_S1) samp_d[1] = rx_s;

      case (state_q)
        c_IDLE: begin
          tick_cnt_d = 4'd0;
          bit_cnt_d  = 3'd0;
          if (!rx_s) state_d = c_START;
        end

        c_START: begin
          if (tick_cnt_q == c_TICK_MID && vote) begin
            // Start bit did not hold low through mid-bit: treat as noise.
            state_d    = c_IDLE;
            tick_cnt_d = 4'd0;
          end else if (tick_cnt_q == c_TICK_LAST) begin
            state_d    = c_DATA;
            tick_cnt_d = 4'd0;
            bit_cnt_d  = 3'd0;
          end else begin
            tick_cnt_d = tick_cnt_q + 4'd1;
          end
        end

        c_DATA: begin
          if (tick_cnt_q == c_TICK_MID) sreg_d = {sreg_q[6:0], vote};
          // 4-bit counter wraps 15 -> 0 on its own.
          tick_cnt_d = tick_cnt_q + 4'd1;
          if (tick_cnt_q == c_TICK_LAST) begin
            if (bit_cnt_q == 3'd7) state_d   = c_STOP;
            else                   bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end

        c_STOP: begin
          // Leave at mid-stop so a back-to-back start edge is not missed.
          if (tick_cnt_q == c_TICK_MID) begin
            state_d    = c_IDLE;
            tick_cnt_d = 4'd0;
          end else begin
            tick_cnt_d = tick_cnt_q + 4'd1;
          end
        end

        default: begin
          state_d    = c_IDLE;
          tick_cnt_d = 4'd0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Output logic. Strobes are one clk wide because their default is 0.
  // --------------------------------------------------------------------------
  always_comb begin
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    busy_d      = (state_d != c_IDLE);

    if (decide && state_q == c_STOP) begin
      rx_data_d   = sreg_q;
      rx_valid_d  = vote;
      frame_err_d = ~vote;
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign busy      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx
// Purpose  : Self-checking bench for uart_rx. A behavioural serial driver
//            builds each 8N1 frame tick by tick; expected bytes come from
//            the values sent.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       baud_tick = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       busy;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] got_q[$];
  int         ferr_cnt  = 0;
  int         both_cnt  = 0;
  logic       busy_seen = 1'b0;
  int         tcnt      = 0;

  uart_rx #(.OVERSAMPLE(16), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .baud_tick (baud_tick),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // One tick every third clock, changed on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      baud_tick = (tcnt == 0);
      tcnt = (tcnt == 2) ? 0 : tcnt + 1;
    end
  end

  // Output collector.
  always @(negedge clk) begin
    if (rx_valid) got_q.push_back(rx_data);
    if (frame_err) ferr_cnt++;
    if (rx_valid && frame_err) both_cnt++;
    if (busy) busy_seen = 1'b1;
  end

  initial begin
    #(10 * 90000);
    $display("FAIL timeout: simulation did not finish, got running required finished");
    $fatal(1);
  end

  // Line level at tick slot s (0..159) of a frame: start, data MSB first, stop.
  function automatic logic frame_level(input logic [7:0] b, input logic stop, input int s);
    int j;
    j = s / 16;
    if (j == 0) return 1'b0;
    if (j == 9) return stop;
    return b[8 - j];
  endfunction

  // Drive one slot and wait for the tick edge that samples it.
  task automatic tick_slot(input logic level);
    rx = level;
    do @(posedge clk); while (baud_tick !== 1'b1);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick_slot(1'b1);
  endtask

  // noise[j] inverts slot offset 8 of frame bit j (0 = start, 1..8 = data).
  task automatic send_frame(input logic [7:0] b, input logic stop, input logic [9:0] noise);
    logic lv;
    for (int s = 0; s < 160; s++) begin
      lv = frame_level(b, stop, s);
      if (noise[s / 16] && (s % 16) == 8) lv = ~lv;
      tick_slot(lv);
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset;
    #1 rst = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    n_checks++; if (rx_data !== 8'h00) $display("FAIL reset_data: got %h required 00", rx_data); else n_pass++;
    n_checks++; if (rx_valid !== 1'b0) $display("FAIL reset_valid: got %b required 0", rx_valid); else n_pass++;
    n_checks++; if (frame_err !== 1'b0) $display("FAIL reset_ferr: got %b required 0", frame_err); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b required 0", busy); else n_pass++;
    rst = 1'b0;
    idle(8);
  endtask

  task automatic test_single;
    int f0;
    got_q.delete(); f0 = ferr_cnt; busy_seen = 1'b0;
    send_frame(8'hA5, 1'b1, 10'd0);
    idle(4);
    n_checks++; if (got_q.size() != 1) $display("FAIL single_count: got %0d required 1", got_q.size()); else n_pass++;
    n_checks++; if (got_q[0] !== 8'hA5) $display("FAIL single_data: got %h required a5", got_q[0]); else n_pass++;
    n_checks++; if (ferr_cnt != f0) $display("FAIL single_ferr: got %0d required %0d", ferr_cnt, f0); else n_pass++;
    n_checks++; if (busy_seen !== 1'b1) $display("FAIL single_busy_seen: got %b required 1", busy_seen); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL single_busy_end: got %b required 0", busy); else n_pass++;
    n_checks++; if (rx_data !== 8'hA5) $display("FAIL single_hold: got %h required a5", rx_data); else n_pass++;
  endtask

  task automatic test_back_to_back;
    logic [7:0] exp[3];
    int f0;
    exp[0] = 8'h00; exp[1] = 8'hFF; exp[2] = 8'h3C;
    got_q.delete(); f0 = ferr_cnt;
    for (int i = 0; i < 3; i++) send_frame(exp[i], 1'b1, 10'd0);
    idle(4);
    n_checks++; if (got_q.size() != 3) $display("FAIL b2b_count: got %0d required 3", got_q.size()); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (got_q[i] !== exp[i]) $display("FAIL b2b_data%0d: got %h required %h", i, got_q[i], exp[i]); else n_pass++;
    end
    n_checks++; if (ferr_cnt != f0) $display("FAIL b2b_ferr: got %0d required %0d", ferr_cnt, f0); else n_pass++;
  endtask

  task automatic test_glitch;
    int f0;
    got_q.delete(); f0 = ferr_cnt;
    for (int s = 0; s < 16; s++) begin
      tick_slot(s < 3 ? 1'b0 : 1'b1);
      if (s == 8) begin
        n_checks++; if (busy !== 1'b1) $display("FAIL glitch_busy_pre: got %b required 1", busy); else n_pass++;
      end
      if (s == 9) begin
        n_checks++; if (busy !== 1'b0) $display("FAIL glitch_busy_post: got %b required 0", busy); else n_pass++;
      end
    end
    n_checks++; if (got_q.size() != 0) $display("FAIL glitch_no_valid: got %0d required 0", got_q.size()); else n_pass++;
    n_checks++; if (ferr_cnt != f0) $display("FAIL glitch_no_ferr: got %0d required %0d", ferr_cnt, f0); else n_pass++;
    idle(4);
    send_frame(8'h5A, 1'b1, 10'd0);
    idle(4);
    n_checks++; if (got_q.size() != 1 || got_q[0] !== 8'h5A)
      $display("FAIL glitch_follow: got n=%0d d=%h required n=1 d=5a", got_q.size(), got_q[0]); else n_pass++;
  endtask

  task automatic test_noise;
    got_q.delete();
    send_frame(8'hF0, 1'b1, 10'b00_0100_0010);
    idle(4);
    n_checks++; if (got_q.size() != 1 || got_q[0] !== 8'hF0)
      $display("FAIL noise_vote: got n=%0d d=%h required n=1 d=f0", got_q.size(), got_q[0]); else n_pass++;
  endtask

  task automatic test_framing;
    int f0;
    got_q.delete(); f0 = ferr_cnt;
    send_frame(8'h3C, 1'b0, 10'd0);
    idle(20);
    n_checks++; if (ferr_cnt != f0 + 1) $display("FAIL ferr_count: got %0d required %0d", ferr_cnt, f0 + 1); else n_pass++;
    n_checks++; if (got_q.size() != 0) $display("FAIL ferr_no_valid: got %0d required 0", got_q.size()); else n_pass++;
    n_checks++; if (rx_data !== 8'h3C) $display("FAIL ferr_data: got %h required 3c", rx_data); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL ferr_busy: got %b required 0", busy); else n_pass++;
    send_frame(8'h81, 1'b1, 10'd0);
    idle(4);
    n_checks++; if (got_q.size() != 1 || got_q[0] !== 8'h81)
      $display("FAIL ferr_recover: got n=%0d d=%h required n=1 d=81", got_q.size(), got_q[0]); else n_pass++;
    n_checks++; if (ferr_cnt != f0 + 1) $display("FAIL ferr_recover_ferr: got %0d required %0d", ferr_cnt, f0 + 1); else n_pass++;
  endtask

  task automatic test_reset_midframe;
    got_q.delete();
    for (int s = 0; s <= 88; s++) tick_slot(frame_level(8'h96, 1'b1, s));
    n_checks++; if (busy !== 1'b1) $display("FAIL mid_busy_before: got %b required 1", busy); else n_pass++;
    #3 rst = 1'b1;
    #1;
    n_checks++; if (rx_data !== 8'h00) $display("FAIL mid_rst_data: got %h required 00", rx_data); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL mid_rst_busy: got %b required 0", busy); else n_pass++;
    n_checks++; if (rx_valid !== 1'b0 || frame_err !== 1'b0)
      $display("FAIL mid_rst_strobes: got %b%b required 00", rx_valid, frame_err); else n_pass++;
    rx = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    idle(16);
    send_frame(8'hC3, 1'b1, 10'd0);
    idle(4);
    n_checks++; if (got_q.size() != 1 || got_q[0] !== 8'hC3)
      $display("FAIL mid_after: got n=%0d d=%h required n=1 d=c3", got_q.size(), got_q[0]); else n_pass++;
  endtask

  task automatic test_loopback;
    logic [7:0] exp_q[$];
    logic [7:0] b;
    int f0;
    int gap;
    got_q.delete(); f0 = ferr_cnt;
    for (int i = 0; i < 80; i++) begin
      b   = 8'($urandom);
      gap = $urandom_range(0, 3);
      exp_q.push_back(b);
      send_frame(b, 1'b1, 10'd0);
      idle(gap);
    end
    idle(4);
    n_checks++; if (got_q.size() != exp_q.size())
      $display("FAIL loop_count: got %0d required %0d", got_q.size(), exp_q.size()); else n_pass++;
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) $display("FAIL loop_data%0d: got %h required %h", i, got_q[i], exp_q[i]); else n_pass++;
    end
    n_checks++; if (ferr_cnt != f0) $display("FAIL loop_ferr: got %0d required %0d", ferr_cnt, f0); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_noise();
    test_framing();
    test_reset_midframe();
    test_loopback();
    n_checks++; if (both_cnt != 0) $display("FAIL strobe_exclusive: got %0d required 0", both_cnt); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
